// File: rtl/updown_counter_mod.sv
// Parametrised up/down modulo counter with load, wrap or saturate policy,
// terminal count, registered wrap pulse and sticky boundary flag.
module updown_counter_mod #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16,
    parameter int MODE    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf_sticky
);

    // Top of range; the cast keeps MODULUS = 2**WIDTH at all-ones.
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
    localparam bit SAT = (MODE != 0);

    // Reject parameter sets outside the representable count range
    if (MODULUS < 2 ||
        longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_params
        $error("updown_counter_mod: illegal MODULUS %0d for WIDTH %0d",
               MODULUS, WIDTH);
    end

    logic             at_top;
    logic             at_bottom;
    logic             at_end;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] next_step;
    logic [WIDTH-1:0] wrap_target;

    // Boundary detection, load clamping and next-step arithmetic
    always_comb begin
        at_top       = (count == MAX);
        at_bottom    = (count == '0);
        at_end       = up ? at_top : at_bottom;
        tc           = enable & at_end;
        load_clamped = (load_value > MAX) ? MAX : load_value;
        next_step    = up ? (count + WIDTH'(1)) : (count - WIDTH'(1));
        wrap_target  = up ? '0 : MAX;
    end

    // Count register with reset > load > enable priority
    always_ff @(posedge clk) begin
        if (!reset) begin
            count      <= '0;
            wrap       <= 1'b0;
            ovf_sticky <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                count <= load_clamped;
            end else if (enable) begin
                if (!at_end) begin
                    count <= next_step;
                end else if (!SAT) begin
                    count <= wrap_target;
                    wrap  <= 1'b1;
                end
            end
            // A boundary step sets the flag and beats a same-cycle clear
            if (!load && tc) begin
                ovf_sticky <= 1'b1;
            end else if (clr_ovf) begin
                ovf_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed self-checking bench for updown_counter_mod.
// Five instances cover the parameter corners exercised below.
module tb_updown_counter_mod;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // a: W4 M16 wrap
    logic       a_reset, a_enable, a_up, a_load, a_clr;
    logic [3:0] a_lv, a_count;
    logic       a_tc, a_wrap, a_ovf;
    // b: W4 M10 wrap
    logic       b_reset, b_enable, b_up, b_load, b_clr;
    logic [3:0] b_lv, b_count;
    logic       b_tc, b_wrap, b_ovf;
    // c: W4 M10 saturate
    logic       c_reset, c_enable, c_up, c_load, c_clr;
    logic [3:0] c_lv, c_count;
    logic       c_tc, c_wrap, c_ovf;
    // d: W1 M2 wrap
    logic       d_reset, d_enable, d_up, d_load, d_clr;
    logic [0:0] d_lv, d_count;
    logic       d_tc, d_wrap, d_ovf;
    // e: W8 M256 wrap
    logic       e_reset, e_enable, e_up, e_load, e_clr;
    logic [7:0] e_lv, e_count;
    logic       e_tc, e_wrap, e_ovf;

    updown_counter_mod #(.WIDTH(4), .MODULUS(16), .MODE(0)) u_a (
        .clk(clk), .reset(a_reset), .enable(a_enable), .up(a_up),
        .load(a_load), .load_value(a_lv), .clr_ovf(a_clr),
        .count(a_count), .tc(a_tc), .wrap(a_wrap), .ovf_sticky(a_ovf));

    updown_counter_mod #(.WIDTH(4), .MODULUS(10), .MODE(0)) u_b (
        .clk(clk), .reset(b_reset), .enable(b_enable), .up(b_up),
        .load(b_load), .load_value(b_lv), .clr_ovf(b_clr),
        .count(b_count), .tc(b_tc), .wrap(b_wrap), .ovf_sticky(b_ovf));

    updown_counter_mod #(.WIDTH(4), .MODULUS(10), .MODE(1)) u_c (
        .clk(clk), .reset(c_reset), .enable(c_enable), .up(c_up),
        .load(c_load), .load_value(c_lv), .clr_ovf(c_clr),
        .count(c_count), .tc(c_tc), .wrap(c_wrap), .ovf_sticky(c_ovf));

    updown_counter_mod #(.WIDTH(1), .MODULUS(2), .MODE(0)) u_d (
        .clk(clk), .reset(d_reset), .enable(d_enable), .up(d_up),
        .load(d_load), .load_value(d_lv), .clr_ovf(d_clr),
        .count(d_count), .tc(d_tc), .wrap(d_wrap), .ovf_sticky(d_ovf));

    updown_counter_mod #(.WIDTH(8), .MODULUS(256), .MODE(0)) u_e (
        .clk(clk), .reset(e_reset), .enable(e_enable), .up(e_up),
        .load(e_load), .load_value(e_lv), .clr_ovf(e_clr),
        .count(e_count), .tc(e_tc), .wrap(e_wrap), .ovf_sticky(e_ovf));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        {a_reset, b_reset, c_reset, d_reset, e_reset} = '0;
        {a_enable, b_enable, c_enable, d_enable, e_enable} = '0;
        {a_load, b_load, c_load, d_load, e_load} = '0;
        {a_clr, b_clr, c_clr, d_clr, e_clr} = '0;
        {a_up, b_up, c_up, d_up, e_up} = '1;
        a_lv = '0; b_lv = '0; c_lv = '0; d_lv = '0; e_lv = '0;
        tick();
        tick();
        tests++;
        if ({a_count, a_wrap, a_ovf} !== 6'd0) begin
            fails++;
            $display("FAIL reset_a: got cnt=%0d w=%b o=%b want 0 0 0",
                     a_count, a_wrap, a_ovf);
        end
        tests++;
        if ({b_count, c_count, d_count, e_count} !== 17'd0) begin
            fails++;
            $display("FAIL reset_others: got %0d %0d %0d %0d want 0",
                     b_count, c_count, d_count, e_count);
        end
        {a_reset, b_reset, c_reset, d_reset, e_reset} = '1;
    endtask

    task automatic test_baseline();
        logic [3:0] ref_cnt;
        logic [3:0] exp;
        int mism;
        ref_cnt = 4'd0;
        mism = 0;
        a_enable = 1'b1;
        a_up = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            ref_cnt = ref_cnt + 4'd1;
            exp = 4'(i % 16);
            tests++;
            if (a_count !== exp || a_wrap !== (exp == 4'd0)) begin
                fails++;
                $display("FAIL base_cnt[%0d]: got %0d/%b want %0d/%b",
                         i, a_count, a_wrap, exp, exp == 4'd0);
            end
            tests++;
            if (a_tc !== (exp == 4'd15) || a_ovf !== (i >= 16)) begin
                fails++;
                $display("FAIL base_flags[%0d]: got tc=%b o=%b want %b %b",
                         i, a_tc, a_ovf, exp == 4'd15, i >= 16);
            end
            if (a_count !== ref_cnt) mism++;
        end
        tests++;
        if (mism != 0) begin
            fails++;
            $display("FAIL miter: got %0d mismatches want 0", mism);
        end
        a_enable = 1'b0;
    endtask

    task automatic test_direction();
        a_enable = 1'b1;
        a_up = 1'b0;
        tick();
        tests++;
        if (a_count !== 4'd3) begin
            fails++;
            $display("FAIL dir_down: got %0d want 3", a_count);
        end
        a_up = 1'b1;
        tick();
        tests++;
        if (a_count !== 4'd4) begin
            fails++;
            $display("FAIL dir_up: got %0d want 4", a_count);
        end
        a_enable = 1'b0;
    endtask

    task automatic test_mod10_down();
        logic [3:0] exp [4] = '{4'd1, 4'd0, 4'd9, 4'd8};
        b_load = 1'b1;
        b_lv = 4'd2;
        tick();
        tests++;
        if (b_count !== 4'd2 || b_wrap !== 1'b0) begin
            fails++;
            $display("FAIL m10_load: got %0d/%b want 2/0", b_count, b_wrap);
        end
        b_load = 1'b0;
        b_up = 1'b0;
        b_enable = 1'b1;
        #1;
        tests++;
        if (b_tc !== 1'b0) begin
            fails++;
            $display("FAIL m10_tc_at2: got %b want 0", b_tc);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (b_count !== exp[i] || b_wrap !== (exp[i] == 4'd9)) begin
                fails++;
                $display("FAIL m10_down[%0d]: got %0d/%b want %0d/%b",
                         i, b_count, b_wrap, exp[i], exp[i] == 4'd9);
            end
            tests++;
            if (b_tc !== (exp[i] == 4'd0)) begin
                fails++;
                $display("FAIL m10_tc[%0d]: got %b want %b",
                         i, b_tc, exp[i] == 4'd0);
            end
        end
        b_enable = 1'b0;
    endtask

    task automatic test_saturate();
        c_load = 1'b1;
        c_lv = 4'd8;
        tick();
        c_load = 1'b0;
        c_up = 1'b1;
        c_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (c_count !== 4'd9 || c_wrap !== 1'b0
                || c_ovf !== (i >= 1)) begin
                fails++;
                $display("FAIL sat[%0d]: got %0d w=%b o=%b want 9 0 %b",
                         i, c_count, c_wrap, c_ovf, i >= 1);
            end
        end
        c_enable = 1'b0;
        c_clr = 1'b1;
        tick();
        tests++;
        if (c_ovf !== 1'b0 || c_count !== 4'd9) begin
            fails++;
            $display("FAIL sat_clr: got o=%b cnt=%0d want 0 9",
                     c_ovf, c_count);
        end
        c_enable = 1'b1;
        tick();
        tests++;
        if (c_ovf !== 1'b1) begin
            fails++;
            $display("FAIL sat_set_wins: got %b want 1", c_ovf);
        end
        c_clr = 1'b0;
        c_enable = 1'b0;
        c_load = 1'b1;
        c_lv = 4'd0;
        tick();
        c_load = 1'b0;
        c_up = 1'b0;
        c_enable = 1'b1;
        tick();
        tests++;
        if (c_count !== 4'd0 || c_wrap !== 1'b0) begin
            fails++;
            $display("FAIL sat_low: got %0d/%b want 0/0", c_count, c_wrap);
        end
        c_enable = 1'b0;
    endtask

    task automatic test_load_clamp();
        b_load = 1'b1;
        b_lv = 4'd13;
        b_enable = 1'b1;
        b_up = 1'b1;
        tick();
        tests++;
        if (b_count !== 4'd9 || b_wrap !== 1'b0) begin
            fails++;
            $display("FAIL clamp: got %0d/%b want 9/0", b_count, b_wrap);
        end
        b_load = 1'b0;
        tick();
        tests++;
        if (b_count !== 4'd0 || b_wrap !== 1'b1) begin
            fails++;
            $display("FAIL clamp_wrap: got %0d/%b want 0/1",
                     b_count, b_wrap);
        end
        b_enable = 1'b0;
    endtask

    task automatic test_reset_mid();
        b_load = 1'b1;
        b_lv = 4'd6;
        tick();
        b_load = 1'b0;
        b_enable = 1'b1;
        b_up = 1'b1;
        tick();
        tests++;
        if (b_count !== 4'd7 || b_ovf !== 1'b1) begin
            fails++;
            $display("FAIL mid_pre: got %0d o=%b want 7 1", b_count, b_ovf);
        end
        b_reset = 1'b0;
        b_load = 1'b1;
        b_lv = 4'd5;
        tick();
        tests++;
        if ({b_count, b_wrap, b_ovf} !== 6'd0) begin
            fails++;
            $display("FAIL mid_rst: got %0d w=%b o=%b want 0 0 0",
                     b_count, b_wrap, b_ovf);
        end
        b_reset = 1'b1;
        b_load = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            tick();
            tests++;
            if (b_count !== 4'(i)) begin
                fails++;
                $display("FAIL mid_resume[%0d]: got %0d want %0d",
                         i, b_count, i);
            end
        end
        b_enable = 1'b0;
    endtask

    task automatic test_back_to_back();
        d_enable = 1'b1;
        d_up = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            tests++;
            if (d_count !== 1'(i % 2) || d_wrap !== (i % 2 == 0)) begin
                fails++;
                $display("FAIL w1[%0d]: got %0d/%b want %0d/%b",
                         i, d_count, d_wrap, i % 2, i % 2 == 0);
            end
        end
        d_enable = 1'b0;
    endtask

    task automatic test_width8();
        e_load = 1'b1;
        e_lv = 8'd254;
        tick();
        e_load = 1'b0;
        e_enable = 1'b1;
        e_up = 1'b1;
        tick();
        tests++;
        if (e_count !== 8'd255 || e_tc !== 1'b1) begin
            fails++;
            $display("FAIL w8_top: got %0d tc=%b want 255 1",
                     e_count, e_tc);
        end
        tick();
        tests++;
        if (e_count !== 8'd0 || e_wrap !== 1'b1 || $isunknown(e_count)) begin
            fails++;
            $display("FAIL w8_wrap: got %0d/%b want 0/1", e_count, e_wrap);
        end
        e_up = 1'b0;
        tick();
        tests++;
        if (e_count !== 8'd255 || e_wrap !== 1'b1) begin
            fails++;
            $display("FAIL w8_down: got %0d/%b want 255/1",
                     e_count, e_wrap);
        end
        e_enable = 1'b0;
        tick();
        tests++;
        if (e_count !== 8'd255 || e_wrap !== 1'b0) begin
            fails++;
            $display("FAIL w8_hold: got %0d/%b want 255/0",
                     e_count, e_wrap);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_baseline();
        test_direction();
        test_mod10_down();
        test_saturate();
        test_load_clamp();
        test_reset_mid();
        test_back_to_back();
        test_width8();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
